axi_dma_cmd_arb: RTL and testbench

Round-robin command arbiter that shares the single `axi_top` DMA command port between `NUM_REQ` requesters. It captures one requester's command at a time into an output register stage and holds it on the downstream `cmd_*` interface until `cmd_ready`. It tags each command with the requester index on `cmd_id` and routes downstream `cmd_abort` pulses back to the owning requester. It sits directly in front of `axi_top`, in place of the bench-driven command source.

---
 rtl/axi_dma_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/axi_dma_cmd_arb.sv | 142 ++++++++++++++
 tb/tb_axi_dma_cmd_arb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_dma_pkg.sv
// Shared encodings for the DMA command path.
// Burst/size codes and arbiter state encoding.
package axi_dma_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_1B   = 3'd0;
  localparam logic [2:0] SIZE_2B   = 3'd1;
  localparam logic [2:0] SIZE_4B   = 3'd2;
  localparam logic [2:0] SIZE_8B   = 3'd3;
  localparam logic [2:0] SIZE_16B  = 3'd4;
  localparam logic [2:0] SIZE_32B  = 3'd5;
  localparam logic [2:0] SIZE_64B  = 3'd6;
  localparam logic [2:0] SIZE_128B = 3'd7;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_ISSUE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// First set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_WD  = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_WD-1:0]  ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_WD-1:0]  gnt_idx
);

  always_comb begin
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] &&
            ((int'(ptr) + k) % NUM_REQ) == i) begin
          found   = 1'b1;
          gnt[i]  = 1'b1;
          gnt_idx = IDX_WD'(i);
        end
      end
    end
  end

endmodule

// File: rtl/axi_dma_cmd_arb.sv
// Round-robin command arbiter in front of axi_top.
// Captures one command, holds it until cmd_ready.
module axi_dma_cmd_arb
  import axi_dma_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int AXI_ID_WD   = 2,
  parameter int AXI_ADDR_WD = 16
) (
  input  logic                           AXI_ACLK,
  input  logic                           AXI_ARESETN,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*AXI_ADDR_WD-1:0] req_addr,
  input  logic [NUM_REQ*2-1:0]           req_burst,
  input  logic [NUM_REQ*3-1:0]           req_size,
  input  logic [NUM_REQ*AXI_ADDR_WD-1:0] req_len,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             req_abort,
  output logic                           cmd_valid,
  output logic [AXI_ADDR_WD-1:0]         cmd_addr,
  output logic [AXI_ID_WD-1:0]           cmd_id,
  output logic [1:0]                     cmd_burst,
  output logic [2:0]                     cmd_size,
  output logic [AXI_ADDR_WD-1:0]         cmd_len,
  input  logic                           cmd_ready,
  input  logic                           cmd_abort,
  output logic                           busy
);

  localparam int IDX_WD = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e state;

  logic [IDX_WD-1:0]      rr_ptr;
  logic [IDX_WD-1:0]      cur_idx;
  logic [IDX_WD-1:0]      owner;
  logic                   owner_vld;
  logic [IDX_WD-1:0]      gnt_idx;
  logic [NUM_REQ-1:0]     gnt;
  logic [NUM_REQ-1:0]     abort_nxt;
  logic [AXI_ADDR_WD-1:0] sel_addr;
  logic [AXI_ADDR_WD-1:0] sel_len;
  logic [1:0]             sel_burst;
  logic [2:0]             sel_size;
  logic                   idle;
  logic                   any_req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_WD  (IDX_WD)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign idle    = (state == ARB_IDLE);
  assign busy    = (state == ARB_ISSUE);
  assign any_req = |req_valid;

  // Gated by reset so the ack is quiet while reset is held.
  assign req_ready = (idle && AXI_ARESETN) ? gnt : '0;

  function automatic logic [IDX_WD-1:0] idx_inc(
    input logic [IDX_WD-1:0] i
  );
    return (int'(i) == NUM_REQ - 1) ? '0 : i + IDX_WD'(1);
  endfunction

  always_comb begin
    sel_addr  = '0;
    sel_len   = '0;
    sel_burst = '0;
    sel_size  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr  = req_addr[i*AXI_ADDR_WD +: AXI_ADDR_WD];
        sel_len   = req_len[i*AXI_ADDR_WD +: AXI_ADDR_WD];
        sel_burst = req_burst[i*2 +: 2];
        sel_size  = req_size[i*3 +: 3];
      end
    end
  end

  // Reject and downstream abort may hit the same bit; OR merges them.
  always_comb begin
    abort_nxt = '0;
    if (cmd_abort && owner_vld)
      abort_nxt[owner] = 1'b1;
    if (idle && any_req && sel_len == '0)
      abort_nxt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      cur_idx   <= '0;
      owner     <= '0;
      owner_vld <= 1'b0;
      req_abort <= '0;
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_id    <= '0;
      cmd_burst <= '0;
      cmd_size  <= '0;
      cmd_len   <= '0;
    end else begin
      req_abort <= abort_nxt;
      unique case (state)
        ARB_IDLE: begin
          if (any_req) begin
            if (sel_len != '0) begin
              state     <= ARB_ISSUE;
              cmd_valid <= 1'b1;
              cmd_addr  <= sel_addr;
              cmd_len   <= sel_len;
              cmd_burst <= sel_burst;
              cmd_size  <= sel_size;
              cmd_id    <= AXI_ID_WD'(gnt_idx);
              cur_idx   <= gnt_idx;
            end else begin
              rr_ptr <= idx_inc(gnt_idx);
            end
          end
        end
        ARB_ISSUE: begin
          if (cmd_ready) begin
            state     <= ARB_IDLE;
            cmd_valid <= 1'b0;
            rr_ptr    <= idx_inc(cur_idx);
            owner     <= cur_idx;
            owner_vld <= 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_dma_cmd_arb.sv
// Bench for axi_dma_cmd_arb.
// Directed scenarios plus random traffic against a cycle model.
module tb_axi_dma_cmd_arb;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_addr;
  logic [N*2-1:0] req_burst;
  logic [N*3-1:0] req_size;
  logic [N*W-1:0] req_len;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_abort;
  logic           cmd_valid;
  logic [W-1:0]   cmd_addr;
  logic [1:0]     cmd_id;
  logic [1:0]     cmd_burst;
  logic [2:0]     cmd_size;
  logic [W-1:0]   cmd_len;
  logic           cmd_ready;
  logic           cmd_abort;
  logic           busy;

  always #5 clk = ~clk;

  axi_dma_cmd_arb #(
    .NUM_REQ     (N),
    .AXI_ID_WD   (2),
    .AXI_ADDR_WD (W)
  ) dut (
    .AXI_ACLK    (clk),
    .AXI_ARESETN (rst_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_burst   (req_burst),
    .req_size    (req_size),
    .req_len     (req_len),
    .req_ready   (req_ready),
    .req_abort   (req_abort),
    .cmd_valid   (cmd_valid),
    .cmd_addr    (cmd_addr),
    .cmd_id      (cmd_id),
    .cmd_burst   (cmd_burst),
    .cmd_size    (cmd_size),
    .cmd_len     (cmd_len),
    .cmd_ready   (cmd_ready),
    .cmd_abort   (cmd_abort),
    .busy        (busy)
  );

  int vectors = 0;
  int errors  = 0;

  // reference state
  bit         m_busy;
  int         m_ptr, m_cur, m_owner;
  bit         m_owner_vld;
  logic [W-1:0] m_addr, m_len;
  logic [1:0] m_burst;
  logic [2:0] m_size;
  int         m_id;
  logic [N-1:0] m_abort;
  int         last_g;
  int         gq[$];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_cur = 0; m_owner = 0;
    m_owner_vld = 0; m_addr = '0; m_len = '0;
    m_burst = '0; m_size = '0; m_id = 0; m_abort = '0;
  endtask

  task automatic set_req(int i, logic [W-1:0] a,
                         logic [W-1:0] l, logic [1:0] b,
                         logic [2:0] s);
    req_addr[i*W +: W]  = a;
    req_len[i*W +: W]   = l;
    req_burst[i*2 +: 2] = b;
    req_size[i*3 +: 3]  = s;
  endtask

  // One clock: called at negedge with inputs already set.
  task automatic step();
    int g;
    logic [N-1:0] nab;
    #1;
    chk("cmd_valid", cmd_valid, m_busy);
    chk("busy", busy, m_busy);
    chk("cmd_addr", cmd_addr, m_addr);
    chk("cmd_len", cmd_len, m_len);
    chk("cmd_burst", cmd_burst, m_burst);
    chk("cmd_size", cmd_size, m_size);
    chk("cmd_id", cmd_id, m_id);
    chk("req_abort", req_abort, m_abort);
    g = -1;
    if (!m_busy)
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(m_ptr + k) % N])
          g = (m_ptr + k) % N;
    chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
    nab = '0;
    if (cmd_abort && m_owner_vld) nab[m_owner] = 1'b1;
    if (m_busy) begin
      if (cmd_ready) begin
        m_busy = 0;
        m_ptr = (m_cur + 1) % N;
        m_owner = m_cur;
        m_owner_vld = 1;
      end
    end else if (g >= 0) begin
      gq.push_back(g);
      if (req_len[g*W +: W] == 0) begin
        nab[g] = 1'b1;
        m_ptr = (g + 1) % N;
      end else begin
        m_busy = 1; m_cur = g; m_id = g;
        m_addr = req_addr[g*W +: W];
        m_len = req_len[g*W +: W];
        m_burst = req_burst[g*2 +: 2];
        m_size = req_size[g*3 +: 3];
      end
    end
    m_abort = nab;
    last_g = g;
    @(negedge clk);
    if (g >= 0) req_valid[g] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; cmd_ready = 0; cmd_abort = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_addr = '0; req_len = '0;
    req_burst = '0; req_size = '0;
    cmd_ready = 0; cmd_abort = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_req_abort", req_abort, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // abort right after reset is ignored
    cmd_abort = 1; step(); cmd_abort = 0;
    chk("abort_no_owner", req_abort, 0);

    // single requester
    set_req(1, 16'h00FF, 16'd1052, 2'd1, 3'd2);
    cmd_ready = 1; req_valid = 4'b0010;
    step();
    chk("single_grant", last_g, 1);
    chk("single_valid", cmd_valid, 1);
    chk("single_id", cmd_id, 1);
    chk("single_addr", cmd_addr, 16'h00FF);
    chk("single_len", cmd_len, 16'd1052);
    step();
    chk("single_drop", cmd_valid, 0);

    // fairness
    do_reset();
    for (int i = 0; i < N; i++)
      set_req(i, 16'(16'h100 * (i + 1)), 16'(i + 5), 2'd1, 3'd3);
    cmd_ready = 1; gq = {};
    for (int c = 0; c < 10; c++) begin
      req_valid = 4'b1111;
      step();
    end
    chk("rr_count", gq.size(), 5);
    for (int k = 0; k < 5 && k < gq.size(); k++)
      chk("rr_order", gq[k], k % 4);

    // backpressure
    do_reset();
    req_valid = 4'b0100; cmd_ready = 0;
    step();
    for (int c = 0; c < 10; c++) begin
      req_valid = 4'b0001;
      step();
      chk("bp_ready0", req_ready, 0);
    end
    cmd_ready = 1; step();
    step();
    chk("bp_next_grant", last_g, 0);

    // zero-length reject
    do_reset();
    set_req(3, 16'h1234, 16'd0, 2'd1, 3'd1);
    req_valid = 4'b1000; step();
    chk("zl_grant", last_g, 3);
    chk("zl_abort", req_abort, 4'b1000);
    chk("zl_no_cmd", cmd_valid, 0);
    set_req(3, 16'h1234, 16'd7, 2'd1, 3'd1);
    req_valid = 4'b1001; step();
    chk("zl_ptr_wrap", last_g, 0);

    // abort routing
    do_reset();
    req_valid = 4'b0100; cmd_ready = 1;
    step(); step();
    cmd_abort = 1; step(); cmd_abort = 0;
    chk("abort_route", req_abort, 4'b0100);
    step();

    // reset mid-ISSUE
    req_valid = 4'b0010; cmd_ready = 0;
    step();
    req_valid = 4'b1111;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", cmd_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_abort", req_abort, 0);
    chk("mid_rst_addr", cmd_addr, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("mid_rst_first", last_g, 0);

    // random traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          set_req(i, 16'($urandom),
                  ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom),
                  2'($urandom_range(0, 2)), 3'($urandom));
        end
      end
      cmd_ready = 1'($urandom_range(0, 1));
      cmd_abort = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
